// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encoding, default bit timing, frame width.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

  localparam int CLK_HZ               = 50_000_000;
  localparam int BAUD                 = 115_200;
  localparam int CLKS_PER_BIT_DEFAULT = CLK_HZ / BAUD;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input; flops come out of reset at RST_VAL.
// Latency: STAGES core clocks from d_i to q_o.
// Backpressure: none, samples every cycle.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_ff: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input in at the LSB; the MSB is the settled value.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Synchroniser chain with synchronous reset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: start detect, mid-bit sampling, one-byte holding register, framing/overrun flags.
// Latency: SYNC_STAGES + 1 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks from start edge to rx_valid.
// Backpressure: rx_valid/rx_ready; a byte completing while the holding register is full and not draining is dropped and sets overrun.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic                 busy
);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx_core: CLKS_PER_BIT must be at least 4");
  end

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]        BIT_LAST = 3'(DATA_BITS - 1);

  logic rxs;

  sync_ff #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(rx_i),
    .q_o(rxs)
  );

  rx_state_t            state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [2:0]           bitidx_q,    bitidx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;
  logic                 busy_q,      busy_d;
  logic                 load;

  // Next-state, bit capture and holding-register/flag update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitidx_d    = bitidx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d    = '0;
          bitidx_d = '0;
          // Line back high at mid-start is a glitch, not a frame.
          state_d  = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          if (bitidx_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bitidx_d = bitidx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            load    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        // Ride out a break: no new start until the line returns high.
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A same-cycle drain frees the register for the new byte.
    if (load && (!rx_valid_q || rx_ready)) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end else if (load) begin
      overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    // Set has priority over clear when they coincide.
    if (clr_overrun && !(load && rx_valid_q && !rx_ready)) begin
      overrun_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // All FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bitidx_q    <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitidx_q    <= bitidx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core at 16 clocks/bit: frame table plus glitch, overrun, drain-on-load and reset-abort sequences.
// Latency: expected good-frame latency is 155 clocks (+/-1) from start edge to rx_valid.
// Backpressure: rx_ready driven by the bench; delivered bytes are checked against a queue of expected bytes.
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx_i;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       clr_overrun;
  logic       busy;

  uart_rx_core #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_overrun(clr_overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       exp_deliver;
    int         exp_ferr;
  } vec_t;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         rise_cyc = -1;
  int         ferr_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Negedge monitor: scoreboard pop on handshake, frame_err pulse count, valid rise time.
  task automatic sample();
    logic [7:0] e;
    if (!rst) begin
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      if (rx_valid && rx_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_delivery: got 0x%0h, expected no byte", rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            n_err++;
            $display("FAIL delivered_byte: got 0x%0h, expected 0x%0h", rx_data, e);
          end
        end
      end
      if (frame_err) ferr_cnt++;
    end
    prev_valid = rx_valid;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    rx_i = 1'b1;
  endtask

  vec_t vecs[7];
  int   ferr0;
  int   lat;
  int   busy_cnt;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 0};
    vecs[1] = '{8'h5A, 1'b1, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1};
    vecs[5] = '{8'h81, 1'b1, 1'b1, 0};
    vecs[6] = '{8'hC3, 1'b1, 1'b1, 0};

    rst = 1'b1;
    rx_i = 1'b1;
    rx_ready = 1'b1;
    clr_overrun = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) tick();
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (5) tick();

    // Short low glitch on the idle line must not start a frame.
    ferr0 = ferr_cnt;
    busy_cnt = 0;
    rx_i = 1'b0;
    repeat (4) begin
      tick();
      if (busy) busy_cnt++;
    end
    rx_i = 1'b1;
    repeat (30) begin
      tick();
      if (busy) busy_cnt++;
    end
    n_cmp++;
    if (busy_cnt < 1 || busy_cnt > 11) begin
      n_err++;
      $display("FAIL glitch_busy_cycles: got %0d, expected 1..11", busy_cnt);
    end
    chk("glitch_no_ferr", ferr_cnt - ferr0, 0);
    chk("glitch_busy_end", busy, 1'b0);

    // Frame table: good frames, one broken stop bit held low as a break.
    for (int v = 0; v < 7; v++) begin
      ferr0 = ferr_cnt;
      rise_cyc = -1;
      if (vecs[v].exp_deliver) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop_ok);
      if (!vecs[v].stop_ok) begin
        rx_i = 1'b0;
        repeat (40) tick();
        rx_i = 1'b1;
      end
      repeat (20) tick();
      chk($sformatf("vec%0d_ferr_pulses", v), ferr_cnt - ferr0, vecs[v].exp_ferr);
      chk($sformatf("vec%0d_queue_drained", v), exp_q.size(), 0);
      chk($sformatf("vec%0d_overrun", v), overrun, 1'b0);
      chk($sformatf("vec%0d_valid_low", v), rx_valid, 1'b0);
      if (vecs[v].exp_deliver) begin
        lat = rise_cyc - start_cyc;
        n_cmp++;
        if (rise_cyc < 0 || lat < 154 || lat > 156) begin
          n_err++;
          $display("FAIL vec%0d_latency: got %0d, expected 155+/-1", v, lat);
        end
      end else begin
        chk($sformatf("vec%0d_no_valid", v), rise_cyc, 32'hFFFF_FFFF);
      end
    end

    // Overrun: two bytes with the consumer stalled; second is dropped.
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (20) tick();
    chk("ovr_valid", rx_valid, 1'b1);
    chk("ovr_data_kept", rx_data, 8'h11);
    chk("ovr_set", overrun, 1'b1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    tick();
    chk("ovr_cleared", overrun, 1'b0);
    chk("ovr_valid_after_clr", rx_valid, 1'b1);
    rx_ready = 1'b1;
    tick();
    tick();
    chk("ovr_drained_valid", rx_valid, 1'b0);
    chk("ovr_drained_queue", exp_q.size(), 0);

    // Drain exactly in the stop-sample cycle of the next byte.
    rx_ready = 1'b0;
    exp_q.push_back(8'h66);
    send_frame(8'h66, 1'b1);
    repeat (5) tick();
    exp_q.push_back(8'h77);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    repeat (5) tick();
    chk("swap_valid", rx_valid, 1'b1);
    chk("swap_data", rx_data, 8'h77);
    chk("swap_overrun", overrun, 1'b0);
    chk("swap_66_taken", exp_q.size(), 1);
    rx_ready = 1'b1;
    tick();
    tick();
    chk("swap_77_taken", exp_q.size(), 0);

    // Reset in the middle of a frame aborts it without delivery.
    rx_i = 1'b0;
    repeat (60) tick();
    rst = 1'b1;
    tick();
    rx_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst_outputs_%0d", i), {rx_data, rx_valid, frame_err, overrun, busy}, 12'h000);
    end
    rst = 1'b0;
    repeat (20) tick();
    chk("rst_idle_after", {rx_valid, busy}, 2'b00);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    repeat (20) tick();
    chk("rst_next_byte", exp_q.size(), 0);
    chk("final_overrun", overrun, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
